// File: rtl/reg_file_rename_pkg.sv
// Shared constants and types for the architectural register file / rename table.
package reg_file_rename_pkg;

  localparam int unsigned ROB_SIZE_BIT = 4;
  localparam int unsigned ROB_SIZE     = 1 << ROB_SIZE_BIT;
  localparam int unsigned REG_NUM      = 32;
  localparam int unsigned REG_IDX_BIT  = 5;

  typedef logic [ROB_SIZE_BIT-1:0] rob_tag_t;
  typedef logic [REG_IDX_BIT-1:0]  reg_idx_t;

  typedef struct packed {
    logic [31:0] val;
    logic        has_dep;
    rob_tag_t    dep;
  } query_resp_t;

endpackage

// File: rtl/reg_file_rename.sv
// Architectural register file plus rename table (x0 hard-wired to zero).
// Optional same-cycle commit forwarding to queries: define RF_COMMIT_BYPASS_EN.
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        issue_valid,
  input  reg_idx_t    issue_rd,
  input  rob_tag_t    issue_rob_idx,
  input  reg_idx_t    query_reg1,
  output logic [31:0] query_val1,
  output logic        query_has_dep1,
  output rob_tag_t    query_dep1,
  input  reg_idx_t    query_reg2,
  output logic [31:0] query_val2,
  output logic        query_has_dep2,
  output rob_tag_t    query_dep2,
  input  reg_idx_t    rob_set_idx,
  input  logic [31:0] rob_set_reg_val,
  input  rob_tag_t    rob_set_recorder
);

  logic [31:0]        r_val [REG_NUM];
  rob_tag_t           r_dep [REG_NUM];
  logic [REG_NUM-1:0] r_dep_valid;

  logic        w_commit;
  logic        w_issue;
  query_resp_t w_q1;
  query_resp_t w_q2;

  assign w_commit = rdy_in && (rob_set_idx != '0);
  assign w_issue  = rdy_in && issue_valid && (issue_rd != '0) && !clear;

  function automatic query_resp_t lookup(input reg_idx_t r);
    query_resp_t resp;
    resp.val     = r_val[r];
    resp.has_dep = r_dep_valid[r];
    resp.dep     = r_dep[r];
`ifdef RF_COMMIT_BYPASS_EN
    // Forward a commit that retires exactly the pending producer of this register.
    if (w_commit && (rob_set_idx == r) && r_dep_valid[r] && (r_dep[r] == rob_set_recorder)) begin
      resp.val     = rob_set_reg_val;
      resp.has_dep = 1'b0;
    end
`endif
    if (r == '0) begin
      resp.val     = '0;
      resp.has_dep = 1'b0;
      resp.dep     = '0;
    end
    return resp;
  endfunction

  always_comb begin
    w_q1 = lookup(query_reg1);
    w_q2 = lookup(query_reg2);
  end

  assign query_val1     = w_q1.val;
  assign query_has_dep1 = w_q1.has_dep;
  assign query_dep1     = w_q1.dep;
  assign query_val2     = w_q2.val;
  assign query_has_dep2 = w_q2.has_dep;
  assign query_dep2     = w_q2.dep;

  // Ordering of the non-blocking writes encodes priority: clear beats commit, issue beats commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_val       <= '{default: '0};
      r_dep       <= '{default: '0};
      r_dep_valid <= '0;
    end else if (rdy_in) begin
      if (w_commit) begin
        r_val[rob_set_idx] <= rob_set_reg_val;
        if (r_dep_valid[rob_set_idx] && (r_dep[rob_set_idx] == rob_set_recorder))
          r_dep_valid[rob_set_idx] <= 1'b0;
      end
      if (clear) begin
        r_dep_valid <= '0;
      end else if (w_issue) begin
        r_dep_valid[issue_rd] <= 1'b1;
        r_dep[issue_rd]       <= issue_rob_idx;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Self-checking bench for reg_file_rename: directed scenarios then randomized traffic
// compared against a behavioural register/rename model.
module tb_reg_file_rename;
  import reg_file_rename_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, issue_valid;
  reg_idx_t    issue_rd, query_reg1, query_reg2, rob_set_idx;
  rob_tag_t    issue_rob_idx, rob_set_recorder, query_dep1, query_dep2;
  logic [31:0] rob_set_reg_val, query_val1, query_val2;
  logic        query_has_dep1, query_has_dep2;

  always #5 clk_in = ~clk_in;

  reg_file_rename dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_idx(issue_rob_idx),
    .query_reg1(query_reg1), .query_val1(query_val1),
    .query_has_dep1(query_has_dep1), .query_dep1(query_dep1),
    .query_reg2(query_reg2), .query_val2(query_val2),
    .query_has_dep2(query_has_dep2), .query_dep2(query_dep2),
    .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val),
    .rob_set_recorder(rob_set_recorder)
  );

  // Reference model: committed value, pending flag and producing tag per register.
  logic [31:0] m_val  [32];
  bit          m_pend [32];
  rob_tag_t    m_tag  [32];

  int checks   = 0;
  int failures = 0;

  logic [31:0] o_v1, o_v2;
  logic        o_h1, o_h2;
  rob_tag_t    o_d1, o_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input reg_idx_t r, input logic [31:0] v,
                          input logic h, input rob_tag_t d);
    logic [31:0] ev;
    logic        eh;
    ev = m_val[r];
    eh = m_pend[r];
`ifdef RF_COMMIT_BYPASS_EN
    if (rdy_in && rob_set_idx == r && rob_set_idx != 0 && m_pend[r] && m_tag[r] == rob_set_recorder) begin
      ev = rob_set_reg_val;
      eh = 1'b0;
    end
`endif
    if (r == 0) begin
      ev = 32'h0;
      eh = 1'b0;
    end
    chk({tag, "_val"}, v, ev);
    chk({tag, "_has_dep"}, {31'b0, h}, {31'b0, eh});
    if (eh) chk({tag, "_dep"}, {{(32-ROB_SIZE_BIT){1'b0}}, d}, {{(32-ROB_SIZE_BIT){1'b0}}, m_tag[r]});
  endtask

  task automatic model_edge();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 32'h0; m_pend[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      int c;
      int d;
      c = int'(rob_set_idx);
      d = int'(issue_rd);
      if (c != 0) begin
        m_val[c] = rob_set_reg_val;
        if (m_pend[c] && m_tag[c] == rob_set_recorder) m_pend[c] = 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (issue_valid && d != 0) begin
        m_pend[d] = 1'b1;
        m_tag[d]  = issue_rob_idx;
      end
    end
  endtask

  // One clock: drive inputs, check the combinational queries, advance the model at the edge.
  task automatic cyc(input bit rst, input bit rdy, input bit clr,
                     input bit iv, input int ird, input int itag,
                     input int cidx, input logic [31:0] cval, input int crec,
                     input int q1, input int q2);
    rst_in = rst; rdy_in = rdy; clear = clr;
    issue_valid = iv; issue_rd = reg_idx_t'(ird); issue_rob_idx = rob_tag_t'(itag);
    rob_set_idx = reg_idx_t'(cidx); rob_set_reg_val = cval; rob_set_recorder = rob_tag_t'(crec);
    query_reg1 = reg_idx_t'(q1); query_reg2 = reg_idx_t'(q2);
    #1;
    o_v1 = query_val1; o_h1 = query_has_dep1; o_d1 = query_dep1;
    o_v2 = query_val2; o_h2 = query_has_dep2; o_d2 = query_dep2;
    if (!rst) begin
      chk_port("q1", query_reg1, o_v1, o_h1, o_d1);
      chk_port("q2", query_reg2, o_v2, o_h2, o_d2);
    end
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  task automatic idle(input int q1, input int q2);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h0, 0, q1, q2);
  endtask

  initial begin
    @(negedge clk_in);
    cyc(1, 1, 0, 0, 0, 0, 0, 32'h0, 0, 5, 0);
    cyc(1, 0, 1, 1, 3, 2, 3, 32'h1, 2, 5, 0);
    idle(5, 0);
    chk("reset_x5_val", o_v1, 32'h0);
    chk("reset_x5_has_dep", {31'b0, o_h1}, 32'h0);

    cyc(0, 1, 0, 0, 0, 0, 0, 32'hDEAD, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 7, 0, 32'hDEAD, 0, 0, 0);
    idle(0, 0);
    chk("x0_val", o_v1, 32'h0);
    chk("x0_has_dep", {31'b0, o_h2}, 32'h0);

    cyc(0, 1, 0, 1, 3, 4, 0, 32'h0, 0, 3, 3);
    idle(3, 0);
    chk("x3_pending", {31'b0, o_h1}, 32'h1);
    chk("x3_tag", {28'b0, 4'(o_d1)}, 32'h4);
    cyc(0, 1, 0, 0, 0, 0, 3, 32'h1234, 4, 0, 0);
    idle(3, 0);
    chk("x3_commit_val", o_v1, 32'h1234);
    chk("x3_commit_has_dep", {31'b0, o_h1}, 32'h0);

    cyc(0, 1, 0, 1, 7, 1, 0, 32'h0, 0, 7, 0);
    cyc(0, 1, 0, 1, 7, 2, 0, 32'h0, 0, 7, 0);
    cyc(0, 1, 0, 0, 0, 0, 7, 32'hAA, 1, 7, 0);
    idle(7, 0);
    chk("x7_val", o_v1, 32'hAA);
    chk("x7_newer_tag", {31'b0, o_h1}, 32'h1);
    chk("x7_dep", {28'b0, 4'(o_d1)}, 32'h2);

    cyc(0, 1, 0, 1, 9, 5, 0, 32'h0, 0, 9, 0);
    cyc(0, 1, 0, 1, 9, 6, 9, 32'h55, 5, 9, 0);
    idle(9, 0);
    chk("x9_val", o_v1, 32'h55);
    chk("x9_dep", {27'b0, o_h1, 4'(o_d1)}, 32'h16);

    cyc(0, 1, 0, 1, 4, 3, 0, 32'h0, 0, 4, 8);
    cyc(0, 1, 0, 1, 8, 0, 0, 32'h0, 0, 4, 8);
    cyc(0, 1, 1, 1, 10, 2, 4, 32'h77, 3, 4, 8);
    idle(4, 8);
    chk("clear_x4_val", o_v1, 32'h77);
    chk("clear_x4_has_dep", {31'b0, o_h1}, 32'h0);
    chk("clear_x8_has_dep", {31'b0, o_h2}, 32'h0);
    idle(10, 0);
    chk("clear_drops_issue", {31'b0, o_h1}, 32'h0);

    cyc(0, 0, 0, 1, 11, 1, 3, 32'hBEEF, 4, 3, 11);
    cyc(0, 0, 1, 1, 12, 1, 4, 32'hBEEF, 4, 3, 11);
    idle(3, 11);
    chk("hold_x3_val", o_v1, 32'h1234);
    chk("hold_x11_has_dep", {31'b0, o_h2}, 32'h0);

    cyc(0, 1, 0, 1, 3, 5, 0, 32'h0, 0, 3, 0);
    cyc(0, 1, 0, 0, 0, 0, 3, 32'hCAFE, 5, 3, 3);
`ifdef RF_COMMIT_BYPASS_EN
    chk("bypass_val", o_v1, 32'hCAFE);
    chk("bypass_has_dep", {31'b0, o_h1}, 32'h0);
`else
    chk("nobypass_val", o_v1, 32'h1234);
    chk("nobypass_dep", {27'b0, o_h1, 4'(o_d1)}, 32'h15);
`endif
    idle(3, 0);
    chk("after_commit_x3", o_v1, 32'hCAFE);

    for (int n = 0; n < 600; n++) begin
      bit          r_rst, r_rdy, r_clr, r_iv;
      int          r_rd, r_itag, r_cidx, r_crec, r_q1, r_q2;
      logic [31:0] r_cval;
      r_rst  = ($urandom_range(0, 79) == 0);
      r_rdy  = ($urandom_range(0, 9) != 0);
      r_clr  = ($urandom_range(0, 24) == 0);
      r_iv   = ($urandom_range(0, 2) != 0);
      r_rd   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      r_itag = $urandom_range(0, 3);
      r_cidx = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 7);
      r_crec = $urandom_range(0, 3);
      r_cval = $urandom;
      r_q1   = $urandom_range(0, 7);
      r_q2   = ($urandom_range(0, 1) == 0) ? r_cidx : $urandom_range(0, 31);
      cyc(r_rst, r_rdy, r_clr, r_iv, r_rd, r_itag, r_cidx, r_cval, r_crec, r_q1, r_q2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
